counter_burst_arbiter: RTL
==========================

Name: counter_burst_arbiter

Overview:
Shares one RandomCounter instance between two requesters. Each requester asks for a burst of enabled counting in its own count mode. The block grants one requester at a time in round-robin order, clears the counter, and drives its enable/mode/reset pins for a fixed burst length. It sits directly in front of the counter's clk/reset/enable/mode inputs; count is routed to requesters externally.

Parameters:
BURST_LEN, 8, number of cycles cnt_enable is held high per grant; legal range 1..2^BEAT_W.
BEAT_W, 3, width of the internal beat counter; 2^BEAT_W >= BURST_LEN is required.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req  input  2  per-requester request, level; bit i = requester i.
req_mode  input  2  per-requester counter mode, sampled only at grant.
gnt  output  2  one-hot grant, high in CLEAR and RUN.
done  output  2  one-hot single-cycle pulse in RELEASE.
cnt_enable  output  1  counter enable.
cnt_mode  output  1  counter mode, frozen for whole burst.
cnt_reset  output  1  counter reset, active-high.
busy  output  1  high whenever state != IDLE.

Behaviour:
- One clock; reset is synchronous, active-high, using port names clk and reset. Reset overrides everything.
- Reset values: state=IDLE, rr pointer=1 (so requester 0 wins first), winner=0, mode latch=0, beat=0. Outputs after reset: gnt=00, done=00, cnt_enable=0, cnt_mode=0, busy=0, cnt_reset=0 (1 with macro).
- Moore outputs, decoded from state and registered winner/mode only. No req→output combinational path.
- FSM, 2-bit encoding: IDLE=00, CLEAR=01, RUN=10, RELEASE=11.
- IDLE:
  - If req!=00: winner = the requester other than the pointer when both request; otherwise the sole requester.
  - Latch req_mode[winner] and go to CLEAR.
  - If req==00, stay in IDLE.
- CLEAR (1 cycle): cnt_reset=1, gnt=onehot(winner), cnt_mode=latched mode; beat cleared; go to RUN.
- RUN:
  - cnt_enable=1, gnt held, beat increments each cycle.
  - Go to RELEASE when beat==BURST_LEN-1 or req[winner]==0 (abort). Abort takes effect the next cycle, so the cycle in which the drop is sampled still has enable=1.
- RELEASE (1 cycle): cnt_enable=0, gnt=00, done=onehot(winner), pointer<=winner; go to IDLE.
- Latency from req sampled in IDLE (cycle 0):
  - gnt at cycle 1.
  - cnt_enable at cycles 2..BURST_LEN+1.
  - done at cycle BURST_LEN+2.
  - Earliest next grant arbitration at cycle BURST_LEN+3.
- req_mode changes after the grant cycle are ignored until the next grant.
- A requester still holding req after its done competes again. Round-robin guarantees alternation when both hold req.
- req bits of the non-winner are ignored during CLEAR/RUN/RELEASE.
- Reset mid-burst: next cycle is IDLE with reset values; any partial burst is discarded with no done pulse.
- BURST_LEN=1: RUN lasts exactly one cycle.

Optional Feature:
IDLE_PARK_EN
- Defined: in IDLE, cnt_reset=1 and cnt_mode=0, so the counter is parked at zero between bursts. The reset value of cnt_reset is 1.
- Undefined: in IDLE, cnt_reset=0 and cnt_enable=0, so the counter holds its last value. Only CLEAR asserts cnt_reset.

Decomposition:
- Shared package counter_arb_pkg: state encodings IDLE/CLEAR/RUN/RELEASE (2-bit), default BURST_LEN=8, BEAT_W=3.
- One natural sub-module: burst_beat_counter, a BEAT_W-bit counter with sync clear, increment enable and a last-beat flag (beat==BURST_LEN-1).
- Arbitration and FSM stay in the top module.

Test Plan (BURST_LEN=8, clk period 10):
- Reset held 3 cycles, req=00 → gnt=00, done=00, cnt_enable=0, busy=0, state IDLE; cnt_reset=0 (1 with IDLE_PARK_EN).
- req=01, req_mode=0 from cycle 0 → gnt=01 at cycle 1 with cnt_reset=1; cnt_enable=1 for exactly cycles 2..9; done=01 at cycle 10; gnt=00 at cycle 10.
- req=11 held, req_mode=10 from reset → grant order 0,1,0. cnt_mode=0 during requester 0 bursts and 1 during requester 1 bursts. Each burst has 8 enable cycles separated by RELEASE+IDLE.
- req=11, requester 0 drops req sampled at cycle 4 (3rd RUN cycle) → cnt_enable high cycles 2..4 only; done=01 at cycle 5; requester 1 wins arbitration at cycle 6, gnt=10 at cycle 7.
- reset pulsed during cycle 5 of a requester 1 burst → next cycle gnt=00, cnt_enable=0, no done pulse; subsequent req=10 granted normally with gnt=10 one cycle after sampling.
- req_mode[0] toggled 0→1 during RUN → cnt_mode stays 0 through RELEASE; next grant to requester 0 uses cnt_mode=1.

Source files
------------

// File: rtl/counter_arb_pkg.sv
// Shared state encoding and default sizing for the counter burst arbiter.
package counter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CLEAR   = 2'b01,
    RUN     = 2'b10,
    RELEASE = 2'b11
  } arb_state_t;

  localparam int DEFAULT_BURST_LEN = 8;
  localparam int DEFAULT_BEAT_W    = 3;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/counter_burst_arbiter_if.sv
// Requester/counter-side signal bundle of the burst arbiter; slave is the arbiter side.
interface counter_burst_arbiter_if;

  logic [1:0] req;
  logic [1:0] req_mode;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       cnt_enable;
  logic       cnt_mode;
  logic       cnt_reset;
  logic       busy;

  modport master (
    output req, req_mode,
    input  gnt, done, cnt_enable, cnt_mode, cnt_reset, busy
  );

  modport slave (
    input  req, req_mode,
    output gnt, done, cnt_enable, cnt_mode, cnt_reset, busy
  );

endinterface

// File: rtl/burst_beat_counter.sv
// Beat counter for one burst: sync clear, increment enable, flag on the final beat.
module burst_beat_counter
  import counter_arb_pkg::*;
#(
  parameter int BURST_LEN = DEFAULT_BURST_LEN,
  parameter int BEAT_W    = DEFAULT_BEAT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [BEAT_W-1:0] beat;

  always_ff @(posedge clk) begin
    if (reset || clear)
      beat <= '0;
    else if (inc)
      beat <= beat + 1'b1;
  end

  assign last = (beat == LAST_BEAT);

endmodule

// File: rtl/counter_burst_arbiter.sv
// Round-robin burst arbiter driving a shared counter's enable/mode/reset pins.
// Build option: define IDLE_PARK_EN to hold the counter in reset between bursts.
module counter_burst_arbiter
  import counter_arb_pkg::*;
#(
  parameter int BURST_LEN = DEFAULT_BURST_LEN,
  parameter int BEAT_W    = DEFAULT_BEAT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  counter_burst_arbiter_if.slave bus
);

  arb_state_t state, state_nxt;
  logic       rr_ptr, rr_ptr_nxt;
  logic       winner, winner_nxt;
  logic       mode_q, mode_nxt;
  logic       beat_clear, beat_inc, beat_last;

  burst_beat_counter #(
    .BURST_LEN(BURST_LEN),
    .BEAT_W   (BEAT_W)
  ) u_beat (
    .clk  (clk),
    .reset(reset),
    .clear(beat_clear),
    .inc  (beat_inc),
    .last (beat_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= 1'b1;
      winner <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      winner <= winner_nxt;
      mode_q <= mode_nxt;
    end
  end

  // Outputs decode only state and registered winner/mode, so req never reaches them.
  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    winner_nxt     = winner;
    mode_nxt       = mode_q;
    beat_clear     = 1'b0;
    beat_inc       = 1'b0;
    bus.gnt        = 2'b00;
    bus.done       = 2'b00;
    bus.cnt_enable = 1'b0;
    bus.cnt_mode   = mode_q;
    bus.cnt_reset  = 1'b0;
    bus.busy       = (state != IDLE);

    case (state)
      IDLE: begin
`ifdef IDLE_PARK_EN
        bus.cnt_reset = 1'b1;
        bus.cnt_mode  = 1'b0;
`endif
        if (bus.req != 2'b00) begin
          winner_nxt = (bus.req == 2'b11) ? ~rr_ptr : bus.req[1];
          mode_nxt   = bus.req_mode[winner_nxt];
          state_nxt  = CLEAR;
        end
      end
      CLEAR: begin
        bus.gnt       = onehot2(winner);
        bus.cnt_reset = 1'b1;
        beat_clear    = 1'b1;
        state_nxt     = RUN;
      end
      RUN: begin
        bus.gnt        = onehot2(winner);
        bus.cnt_enable = 1'b1;
        beat_inc       = 1'b1;
        if (beat_last || !bus.req[winner])
          state_nxt = RELEASE;
      end
      RELEASE: begin
        bus.done   = onehot2(winner);
        rr_ptr_nxt = winner;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
